// File: rtl/mult_pkg.sv
// Shared types and helpers for the E-stage multiply sequencer.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIX,
    WRHI,
    WRLO
  } multState;

  // MultControl (InstrE[23:21]) field positions: 000 MUL, 001 MLA, 100 UMULL,
  // 101 UMLAL, 110 SMULL, 111 SMLAL.
  localparam int unsigned MC_ACC_BIT    = 0;
  localparam int unsigned MC_SIGNED_BIT = 1;
  localparam int unsigned MC_LONG_BIT   = 2;

  function automatic int unsigned multSteps(input int unsigned stepW);
    return 32 / stepW;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One iteration of the shared multiplier: 32xSTEP_W partial product, shifted into the 64-bit accumulator.
module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned STEP_W = 8,
  parameter int unsigned CNT_W  = 2
) (
  input  logic [31:0]      rmMag,
  input  logic [31:0]      rsMag,
  input  logic [CNT_W-1:0] count,
  input  logic [63:0]      accIn,
  output logic [63:0]      accOut
);

  logic [STEP_W-1:0] rsChunk;
  logic [63:0]       partial;

  always_comb begin
    rsChunk = rsMag[STEP_W*count +: STEP_W];
    partial = 64'(rmMag) * 64'(rsChunk);
    accOut  = accIn + (partial << (STEP_W * count));
  end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL sequencer for the Execute stage.
// Optional early termination on short multipliers: define MULT_EARLY_TERM_EN.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [2:0]  MultControlE,
  input  logic        SetFlagsE,
  input  logic        FlushE,
  input  logic [31:0] RmE,
  input  logic [31:0] RsE,
  input  logic [31:0] AccLoE,
  input  logic [31:0] AccHiE,
  input  logic [3:0]  FlagsE,
  output logic        BusyE,
  output logic        WriteHiE,
  output logic        WriteLoE,
  output logic [31:0] ResultE,
  output logic        DoneE,
  output logic [3:0]  MultFlagsE
);

  localparam int unsigned STEPS = multSteps(STEP_W);
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  multState         state;
  logic [CNT_W-1:0] count;
  logic [63:0]      acc;
  logic [63:0]      accNext;
  logic [31:0]      rmMag;
  logic [31:0]      rsMag;
  logic             neg;
  logic             isLong;
  logic             doAcc;
  logic             setFlags;
  logic [31:0]      resultLo;
  logic             lastIter;
  logic             signedOp;
  logic [63:0]      prod;
  logic [63:0]      addend;
  logic [63:0]      fixSum;
  logic             resN;
  logic             resZ;

  mult_step #(
    .STEP_W(STEP_W),
    .CNT_W (CNT_W)
  ) u_step (
    .rmMag (rmMag),
    .rsMag (rsMag),
    .count (count),
    .accIn (acc),
    .accOut(accNext)
  );

`ifdef MULT_EARLY_TERM_EN
  // Stop once no multiplier bits remain above the chunk being consumed now.
  assign lastIter = (count == LAST) ||
                    ((rsMag >> (STEP_W * (32'(count) + 32'd1))) == 32'd0);
`else
  assign lastIter = (count == LAST);
`endif

  assign signedOp = MultControlE[MC_LONG_BIT] & MultControlE[MC_SIGNED_BIT];

  // Sign fix-up, accumulate and flag generation for the FIX cycle.
  always_comb begin
    prod   = neg ? -acc : acc;
    addend = 64'd0;
    if (doAcc) addend = isLong ? {AccHiE, AccLoE} : {32'd0, AccLoE};
    fixSum = prod + addend;
    resN   = isLong ? fixSum[63] : fixSum[31];
    resZ   = isLong ? (fixSum == 64'd0) : (fixSum[31:0] == 32'd0);
  end

  // Strobes are state decodes; a flush kills them in the same cycle.
  assign BusyE    = ((state == IDLE) & StartE) | (state == ITER) |
                    (state == FIX) | (state == WRHI);
  assign WriteHiE = (state == WRHI) & ~FlushE;
  assign WriteLoE = (state == WRLO) & ~FlushE;
  assign DoneE    = (state == WRLO) & ~FlushE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= 64'd0;
      rmMag      <= 32'd0;
      rsMag      <= 32'd0;
      neg        <= 1'b0;
      isLong     <= 1'b0;
      doAcc      <= 1'b0;
      setFlags   <= 1'b0;
      resultLo   <= 32'd0;
      ResultE    <= 32'd0;
      MultFlagsE <= 4'd0;
    end else begin
      ResultE <= 32'd0;
      case (state)
        IDLE: begin
          if (StartE && !FlushE) begin
            isLong   <= MultControlE[MC_LONG_BIT];
            doAcc    <= MultControlE[MC_ACC_BIT];
            setFlags <= SetFlagsE;
            rmMag    <= (signedOp && RmE[31]) ? -RmE : RmE;
            rsMag    <= (signedOp && RsE[31]) ? -RsE : RsE;
            neg      <= signedOp && (RmE[31] ^ RsE[31]);
            acc      <= 64'd0;
            count    <= '0;
            state    <= ITER;
          end
        end
        ITER: begin
          if (FlushE) begin
            state <= IDLE;
          end else begin
            acc   <= accNext;
            count <= count + CNT_W'(1);
            if (lastIter) state <= FIX;
          end
        end
        FIX: begin
          if (FlushE) begin
            state <= IDLE;
          end else begin
            resultLo   <= fixSum[31:0];
            ResultE    <= isLong ? fixSum[63:32] : fixSum[31:0];
            MultFlagsE <= setFlags ? {resN, resZ, FlagsE[1:0]} : FlagsE;
            state      <= isLong ? WRHI : WRLO;
          end
        end
        WRHI: begin
          if (FlushE) begin
            state <= IDLE;
          end else begin
            ResultE <= resultLo;
            state   <= WRLO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer against an arithmetic reference model.
module tb_mult_sequencer;

  localparam int unsigned STEP_W = 8;
  localparam int STEPS = 32 / STEP_W;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [2:0]  MultControlE;
  logic        SetFlagsE;
  logic        FlushE;
  logic [31:0] RmE, RsE, AccLoE, AccHiE;
  logic [3:0]  FlagsE;
  logic        BusyE, WriteHiE, WriteLoE, DoneE;
  logic [31:0] ResultE;
  logic [3:0]  MultFlagsE;

  int nChecks = 0;
  int nPass   = 0;

  // Observations from the most recent operation.
  logic [31:0] busyMask;
  int          hiCnt, loCnt, doneCnt, hiCyc, loCyc, doneCyc;
  logic [31:0] hiData, loData;
  logic [3:0]  flagsDone;

  always #5 clk = ~clk;

  mult_sequencer #(.STEP_W(STEP_W)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .MultControlE(MultControlE),
    .SetFlagsE(SetFlagsE), .FlushE(FlushE), .RmE(RmE), .RsE(RsE),
    .AccLoE(AccLoE), .AccHiE(AccHiE), .FlagsE(FlagsE), .BusyE(BusyE),
    .WriteHiE(WriteHiE), .WriteLoE(WriteLoE), .ResultE(ResultE),
    .DoneE(DoneE), .MultFlagsE(MultFlagsE)
  );

  // Full-width reference result from the instruction's arithmetic meaning.
  function automatic logic [63:0] expResult(input logic [2:0] ctrl,
      input logic [31:0] rm, input logic [31:0] rs,
      input logic [31:0] lo, input logic [31:0] hi);
    longint sp;
    logic [63:0] r;
    sp = longint'(int'(rm)) * longint'(int'(rs));
    case (ctrl)
      3'b000:  r = {32'd0, rm * rs};
      3'b001:  r = {32'd0, rm * rs + lo};
      3'b100:  r = 64'(rm) * 64'(rs);
      3'b101:  r = 64'(rm) * 64'(rs) + {hi, lo};
      3'b110:  r = 64'(sp);
      default: r = 64'(sp) + {hi, lo};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] expFlags(input logic [2:0] ctrl, input logic s,
      input logic [63:0] r, input logic [3:0] fl);
    logic n, z;
    n = ctrl[2] ? r[63] : r[31];
    z = ctrl[2] ? (r == 64'd0) : (r[31:0] == 32'd0);
    return s ? {n, z, fl[1:0]} : fl;
  endfunction

  // Cycle on which DoneE is expected, counted from the StartE cycle.
  function automatic int expDone(input logic [2:0] ctrl, input logic [31:0] rs);
    logic [31:0] mag;
    int sig;
    mag = (ctrl[2] && ctrl[1] && rs[31]) ? -rs : rs;
    sig = 1;
    for (int k = 1; k < STEPS; k++)
      if ((mag >> (STEP_W * k)) != 32'd0) sig = k + 1;
    return (EARLY ? sig : STEPS) + (ctrl[2] ? 3 : 2);
  endfunction

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one operation at the current cycle and record what the DUT does.
  task automatic doOp(input logic [2:0] ctrl, input logic s, input logic [31:0] rm,
      input logic [31:0] rs, input logic [31:0] lo, input logic [31:0] hi,
      input logic [3:0] fl, input int flushAt);
    bit stop;
    MultControlE = ctrl; SetFlagsE = s; RmE = rm; RsE = rs;
    AccLoE = lo; AccHiE = hi; FlagsE = fl; StartE = 1'b1; FlushE = 1'b0;
    busyMask = '0; hiCnt = 0; loCnt = 0; doneCnt = 0;
    hiCyc = -1; loCyc = -1; doneCyc = -1; hiData = '0; loData = '0; flagsDone = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      busyMask[c] = BusyE;
      if (WriteHiE) begin hiCnt++; hiCyc = c; hiData = ResultE; end
      if (WriteLoE) begin loCnt++; loCyc = c; loData = ResultE; end
      if (DoneE) begin doneCnt++; doneCyc = c; flagsDone = MultFlagsE; end
      stop = DoneE || (c == flushAt);
      @(posedge clk); #1;
      StartE = 1'b0;
      FlushE = !stop && (c + 1 == flushAt);
      if (stop) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; StartE = 1'b0; FlushE = 1'b0; MultControlE = 3'd0; SetFlagsE = 1'b0;
    RmE = '0; RsE = '0; AccLoE = '0; AccHiE = '0; FlagsE = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    nChecks++;
    if ({BusyE, WriteHiE, WriteLoE, DoneE, ResultE, MultFlagsE} !== 40'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {BusyE, WriteHiE, WriteLoE, DoneE, ResultE, MultFlagsE});
    else nPass++;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_directed;
    int d;
    // MUL 7*6
    d = expDone(3'b000, 32'd6);
    doOp(3'b000, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, 4'd0, -1);
    nChecks++;
    if (doneCyc !== d) $display("FAIL mul_done_cycle: got %0d want %0d", doneCyc, d);
    else nPass++;
    nChecks++;
    if (busyMask !== (32'd1 << d) - 32'd1)
      $display("FAIL mul_busy: got %h want %h", busyMask, (32'd1 << d) - 32'd1);
    else nPass++;
    nChecks++;
    if (loData !== 32'h0000002A || loCyc !== d || hiCnt !== 0)
      $display("FAIL mul_result: got %h@%0d hi=%0d want 0000002a@%0d hi=0", loData, loCyc, hiCnt, d);
    else nPass++;
    gap(1);
    // SMULL -2*3 with S
    doOp(3'b110, 1'b1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 4'b0011, -1);
    nChecks++;
    if (hiData !== 32'hFFFFFFFF || hiCyc !== doneCyc - 1)
      $display("FAIL smull_hi: got %h@%0d want ffffffff@%0d", hiData, hiCyc, doneCyc - 1);
    else nPass++;
    nChecks++;
    if (loData !== 32'hFFFFFFFA) $display("FAIL smull_lo: got %h want fffffffa", loData);
    else nPass++;
    nChecks++;
    if (flagsDone !== 4'b1011) $display("FAIL smull_flags: got %b want 1011", flagsDone);
    else nPass++;
    // UMLAL max*max + 1, issued back-to-back
    doOp(3'b101, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd0, -1);
    nChecks++;
    if ({hiData, loData} !== 64'hFFFFFFFE_00000002)
      $display("FAIL umlal_result: got %h want fffffffe00000002", {hiData, loData});
    else nPass++;
    gap(2);
    // MLA 0*5 + 0 with S
    doOp(3'b001, 1'b1, 32'd0, 32'd5, 32'd0, 32'hDEADBEEF, 4'b1001, -1);
    nChecks++;
    if (loData !== 32'd0 || flagsDone !== 4'b0101)
      $display("FAIL mla_zero: got %h flags %b want 0 flags 0101", loData, flagsDone);
    else nPass++;
    gap(1);
  endtask

  task automatic test_flush;
    logic [63:0] exp;
    doOp(3'b000, 1'b0, 32'h12345678, 32'h87654321, 32'd0, 32'd0, 4'd0, 2);
    nChecks++;
    if (hiCnt + loCnt + doneCnt !== 0)
      $display("FAIL flush_strobes: got %0d want 0", hiCnt + loCnt + doneCnt);
    else nPass++;
    nChecks++;
    if (busyMask !== 32'h7) $display("FAIL flush_busy: got %h want 00000007", busyMask);
    else nPass++;
    // New start in the cycle right after the flush must be accepted.
    exp = expResult(3'b000, 32'd9, 32'd11, 32'd0, 32'd0);
    doOp(3'b000, 1'b0, 32'd9, 32'd11, 32'd0, 32'd0, 4'd0, -1);
    nChecks++;
    if (loData !== exp[31:0] || loCnt !== 1 || doneCyc !== expDone(3'b000, 32'd11))
      $display("FAIL flush_restart: got %h@%0d want %h@%0d", loData, doneCyc,
               exp[31:0], expDone(3'b000, 32'd11));
    else nPass++;
    gap(1);
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    doOp(3'b111, 1'b1, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h2, 4'b0100, -1);
    exp = expResult(3'b101, 32'hCAFEF00D, 32'h00000123, 32'h5, 32'h6);
    doOp(3'b101, 1'b0, 32'hCAFEF00D, 32'h00000123, 32'h5, 32'h6, 4'b0110, -1);
    nChecks++;
    if ({hiData, loData} !== exp || doneCyc !== expDone(3'b101, 32'h123))
      $display("FAIL b2b_second: got %h@%0d want %h@%0d", {hiData, loData}, doneCyc,
               exp, expDone(3'b101, 32'h123));
    else nPass++;
    gap(1);
  endtask

  task automatic test_midreset;
    int stray;
    logic [63:0] exp;
    stray = 0;
    MultControlE = 3'b100; RmE = 32'hFFFF0000; RsE = 32'hFF00FF00; StartE = 1'b1;
    @(posedge clk); #1; StartE = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        nChecks++;
        if ({BusyE, WriteHiE, WriteLoE, DoneE, ResultE, MultFlagsE} !== 40'd0)
          $display("FAIL midreset_outputs: got %h want 0",
                   {BusyE, WriteHiE, WriteLoE, DoneE, ResultE, MultFlagsE});
        else nPass++;
      end
      if (BusyE || WriteHiE || WriteLoE || DoneE) stray++;
      @(posedge clk); #1;
    end
    nChecks++;
    if (stray !== 0) $display("FAIL midreset_stray: got %0d want 0", stray);
    else nPass++;
    exp = expResult(3'b100, 32'd1000, 32'd1000, 32'd0, 32'd0);
    doOp(3'b100, 1'b0, 32'd1000, 32'd1000, 32'd0, 32'd0, 4'd0, -1);
    nChecks++;
    if ({hiData, loData} !== exp) $display("FAIL midreset_recover: got %h want %h", {hiData, loData}, exp);
    else nPass++;
    gap(1);
  endtask

  task automatic test_random;
    logic [2:0]  ctrls [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [2:0]  ctrl;
    logic        s;
    logic [31:0] rm, rs, lo, hi;
    logic [3:0]  fl;
    logic [63:0] exp;
    int          d, sel;
    for (int i = 0; i < 40; i++) begin
      ctrl = ctrls[$urandom_range(0, 5)];
      s = 1'($urandom); rm = $urandom; lo = $urandom; hi = $urandom; fl = 4'($urandom);
      sel = $urandom_range(0, 2);
      rs = (sel == 0) ? 32'($urandom_range(0, 70000)) :
           (sel == 1) ? -32'($urandom_range(0, 70000)) : $urandom;
      exp = expResult(ctrl, rm, rs, lo, hi);
      d = expDone(ctrl, rs);
      doOp(ctrl, s, rm, rs, lo, hi, fl, -1);
      nChecks++;
      if (doneCyc !== d || doneCnt !== 1)
        $display("FAIL rnd%0d_done: got %0d x%0d want %0d x1", i, doneCyc, doneCnt, d);
      else nPass++;
      nChecks++;
      if (busyMask !== (32'd1 << d) - 32'd1)
        $display("FAIL rnd%0d_busy: got %h want %h", i, busyMask, (32'd1 << d) - 32'd1);
      else nPass++;
      nChecks++;
      if (loData !== exp[31:0] || loCyc !== d)
        $display("FAIL rnd%0d_lo: got %h@%0d want %h@%0d", i, loData, loCyc, exp[31:0], d);
      else nPass++;
      nChecks++;
      if (hiCnt !== (ctrl[2] ? 1 : 0) || (ctrl[2] && hiData !== exp[63:32]))
        $display("FAIL rnd%0d_hi: got %h x%0d want %h x%0d", i, hiData, hiCnt, exp[63:32], ctrl[2] ? 1 : 0);
      else nPass++;
      nChecks++;
      if (flagsDone !== expFlags(ctrl, s, exp, fl))
        $display("FAIL rnd%0d_flags: got %b want %b", i, flagsDone, expFlags(ctrl, s, exp, fl));
      else nPass++;
      gap($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", nPass, nChecks);
    $fatal(1, "watchdog");
  end

endmodule
